mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter DATA, default 32, datapath and address width in bits.
REQ-002 Parameter TIMEOUT, default 15, maximum cycles waiting for dmem_ack before abort (1..255).
REQ-003 Single clock; reset is synchronous and active-high: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-004 ex_valid input 1, execute result present this cycle.
REQ-005 ex_alu_o input DATA, ALU result / memory address.
REQ-006 ex_write_data input DATA, store data.
REQ-007 ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg input 1 each, control bits.
REQ-008 ex_rd input 5, destination register index.
REQ-009 ex_is_taken input 1; ex_new_addr input DATA, branch/jump outcome and target.
REQ-010 stall_o output 1, upstream must hold its outputs while high.
REQ-011 dmem_req output 1; dmem_we output 1; dmem_addr output DATA; dmem_wdata output DATA, data memory request.
REQ-012 dmem_ack input 1; dmem_rdata input DATA, memory completion and load data.
REQ-013 wb_valid output 1; wb_reg_write output 1; wb_rd output 5; wb_data output DATA, writeback result.
REQ-014 redirect_valid output 1; redirect_addr output DATA, PC redirect to fetch.
REQ-015 err_misalign output 1; err_timeout output 1, single-cycle error pulses.

Function
REQ-016 FSM states IDLE and BUSY; stall_o SHALL equal (state==BUSY), combinational.
REQ-017 In IDLE, ex_valid sampled at rising edge; ex inputs ignored in BUSY and when ex_valid=0.
REQ-018 Non-memory op (mem_read=mem_write=0): next cycle wb_valid=1, wb_reg_write=ex_reg_write, wb_rd=ex_rd, wb_data=ex_alu_o; latency 1, stays IDLE.
REQ-019 Memory op with ex_alu_o[1:0]==0: IDLE->BUSY; next cycle dmem_req=1, dmem_we=ex_mem_write, dmem_addr=ex_alu_o, dmem_wdata=ex_write_data, all held stable until ack or abort.
REQ-020 mem_read and mem_write both set: treated as store (dmem_we=1).
REQ-021 BUSY with dmem_ack=1: dmem_req drops next cycle, state->IDLE; next cycle wb_valid=1, wb_rd, wb_reg_write as captured; wb_data=dmem_rdata (sampled in ack cycle) if mem_to_reg, else captured alu_o.
REQ-022 Store completion: wb_valid=1, wb_reg_write forced 0.
REQ-023 Wait counter cleared on BUSY entry, increments each BUSY cycle without ack; reaching TIMEOUT without ack: dmem_req drops, state->IDLE, err_timeout pulses 1 cycle, wb_valid=1 with wb_reg_write=0.
REQ-024 dmem_ack in the same cycle the counter reaches TIMEOUT: ack wins, normal completion, no err_timeout.
REQ-025 dmem_ack while IDLE or dmem_req=0: ignored.
REQ-026 Misaligned memory op (ex_alu_o[1:0]!=0): no dmem request, stays IDLE; next cycle err_misalign=1, wb_valid=1, wb_reg_write=0.
REQ-027 ex_valid with ex_is_taken=1 (any state-accepting cycle): next cycle redirect_valid=1 for exactly 1 cycle, redirect_addr=ex_new_addr; independent of memory op.
REQ-028 wb_valid, redirect_valid, err_* are single-cycle pulses; unaffected outputs hold value, wb_valid=0 otherwise.
REQ-029 Back-to-back non-memory ops produce one wb_valid per cycle, no bubbles.

Reset
REQ-030 rst high at a rising edge: state=IDLE, counter=0, all outputs 0 next cycle, including stall_o.
REQ-031 rst during BUSY aborts the access: dmem_req=0 next cycle, no wb_valid, no error pulse, pending ack discarded.

Verification
REQ-032 ADD result: ex_valid=1, alu_o=0x0000_0010, reg_write=1, rd=5 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x10, stall_o=0.
REQ-033 Load addr 0x100, ack after 3 cycles with rdata=0xDEADBEEF -> dmem_req high 3 cycles at addr 0x100, stall_o high 3 cycles, then wb_data=0xDEADBEEF, wb_rd as given.
REQ-034 Store addr 0x104, data 0x55 -> dmem_we=1, dmem_wdata=0x55 until ack; completion wb_valid=1, wb_reg_write=0.
REQ-035 Load addr 0x102 -> no dmem_req, err_misalign pulse next cycle, wb_reg_write=0.
REQ-036 Load, no ack, TIMEOUT=4 -> dmem_req drops after 4 BUSY cycles, err_timeout pulse, stall_o released; repeat with ack in cycle 4 -> normal completion.
REQ-037 Taken branch ex_new_addr=0x40 with rst asserted mid-load -> redirect_valid pulse, addr 0x40; rst clears all outputs, no wb_valid from aborted load.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage. It passes ALU results to writeback, runs one aligned
// data-memory transaction at a time with a wait timeout, and forwards branch redirects.
module mem_access_stage #(
    parameter int DATA    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [DATA-1:0] ex_alu_o,
    input  logic [DATA-1:0] ex_write_data,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic            ex_reg_write,
    input  logic            ex_mem_to_reg,
    input  logic [4:0]      ex_rd,
    input  logic            ex_is_taken,
    input  logic [DATA-1:0] ex_new_addr,
    output logic            stall_o,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [DATA-1:0] dmem_addr,
    output logic [DATA-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [DATA-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic [4:0]      wb_rd,
    output logic [DATA-1:0] wb_data,
    output logic            redirect_valid,
    output logic [DATA-1:0] redirect_addr,
    output logic            err_misalign,
    output logic            err_timeout
);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_cnt;
    logic            r_reg_write;
    logic            r_mem_to_reg;
    logic            r_is_store;
    logic [4:0]      r_rd;
    logic [DATA-1:0] r_alu;

    logic w_accept;
    logic w_mem_op;
    logic w_misalign;
    logic w_ack_done;
    logic w_timeout;

    assign stall_o = (r_state == BUSY);

    // Decode the accepted op and the two ways a pending access can finish.
    always_comb begin
        w_accept    = 1'b0;
        w_mem_op    = 1'b0;
        w_misalign  = 1'b0;
        w_ack_done  = 1'b0;
        w_timeout   = 1'b0;
        w_state_nxt = r_state;
        w_accept    = (r_state == IDLE) && ex_valid;
        w_mem_op    = ex_mem_read || ex_mem_write;
        w_misalign  = (ex_alu_o[1:0] != 2'b00);
        w_ack_done  = (r_state == BUSY) && dmem_req && dmem_ack;
        // An ack in the final allowed cycle takes priority over the abort.
        w_timeout   = (r_state == BUSY) && dmem_req && !dmem_ack
                      && ((r_cnt + 8'd1) == TO_LIMIT);
        case (r_state)
            IDLE: begin
                if (w_accept && w_mem_op && !w_misalign) begin
                    w_state_nxt = BUSY;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (w_ack_done || w_timeout) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs, captured request context and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= 8'd0;
            r_reg_write    <= 1'b0;
            r_mem_to_reg   <= 1'b0;
            r_is_store     <= 1'b0;
            r_rd           <= 5'd0;
            r_alu          <= '0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_rd          <= 5'd0;
            wb_data        <= '0;
            redirect_valid <= 1'b0;
            redirect_addr  <= '0;
            err_misalign   <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            wb_valid       <= 1'b0;
            redirect_valid <= 1'b0;
            err_misalign   <= 1'b0;
            err_timeout    <= 1'b0;
            if (w_accept) begin
                if (ex_is_taken) begin
                    redirect_valid <= 1'b1;
                    redirect_addr  <= ex_new_addr;
                end
                if (!w_mem_op) begin
                    wb_valid     <= 1'b1;
                    wb_reg_write <= ex_reg_write;
                    wb_rd        <= ex_rd;
                    wb_data      <= ex_alu_o;
                end else if (w_misalign) begin
                    err_misalign <= 1'b1;
                    wb_valid     <= 1'b1;
                    wb_reg_write <= 1'b0;
                    wb_rd        <= ex_rd;
                end else begin
                    // Load+store together is treated as a store.
                    dmem_req     <= 1'b1;
                    dmem_we      <= ex_mem_write;
                    dmem_addr    <= ex_alu_o;
                    dmem_wdata   <= ex_write_data;
                    r_cnt        <= 8'd0;
                    r_reg_write  <= ex_reg_write;
                    r_mem_to_reg <= ex_mem_to_reg;
                    r_is_store   <= ex_mem_write;
                    r_rd         <= ex_rd;
                    r_alu        <= ex_alu_o;
                end
            end else if (w_ack_done) begin
                dmem_req     <= 1'b0;
                dmem_we      <= 1'b0;
                wb_valid     <= 1'b1;
                wb_reg_write <= r_reg_write && !r_is_store;
                wb_rd        <= r_rd;
                wb_data      <= r_mem_to_reg ? dmem_rdata : r_alu;
            end else if (w_timeout) begin
                dmem_req     <= 1'b0;
                dmem_we      <= 1'b0;
                err_timeout  <= 1'b1;
                wb_valid     <= 1'b1;
                wb_reg_write <= 1'b0;
                wb_rd        <= r_rd;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a table of single-cycle ops plus hand-written
// sequences for load/store waits, timeout, ack-at-limit and reset mid-access.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_o;
    logic [31:0] ex_write_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        ex_mem_to_reg;
    logic [4:0]  ex_rd;
    logic        ex_is_taken;
    logic [31:0] ex_new_addr;
    logic        stall_o;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        err_misalign;
    logic        err_timeout;

    int errors = 0;
    int checks = 0;

    mem_access_stage #(.DATA(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_alu_o(ex_alu_o), .ex_write_data(ex_write_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
        .ex_is_taken(ex_is_taken), .ex_new_addr(ex_new_addr),
        .stall_o(stall_o),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .err_misalign(err_misalign), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] alu;
        logic        mr, mw, rw, m2r;
        logic [4:0]  rd;
        logic        tk;
        logic [31:0] na;
        logic        e_wbv, e_rw;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_mis;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                          input logic mr, input logic mw, input logic rw, input logic m2r,
                          input logic [4:0] rd, input logic tk, input logic [31:0] na);
        ex_valid      = v;
        ex_alu_o      = alu;
        ex_write_data = wd;
        ex_mem_read   = mr;
        ex_mem_write  = mw;
        ex_reg_write  = rw;
        ex_mem_to_reg = m2r;
        ex_rd         = rd;
        ex_is_taken   = tk;
        ex_new_addr   = na;
    endtask

    task automatic idle_ex();
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    endtask

    initial begin
        // v alu mr mw rw m2r rd tk na | wbv rw rd data rv ra mis
        vecs[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 32'h0,
                    1'b1, 1'b1, 5'd5, 32'h10, 1'b0, 32'h0, 1'b0};
        vecs[1] = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b0, 32'h0,
                    1'b1, 1'b0, 5'd7, 32'h20, 1'b0, 32'h0, 1'b0};
        vecs[2] = '{1'b0, 32'h99, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 1'b1, 32'h88,
                    1'b0, 1'b0, 5'd7, 32'h20, 1'b0, 32'h0, 1'b0};
        vecs[3] = '{1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 32'h40,
                    1'b1, 1'b1, 5'd1, 32'h44, 1'b1, 32'h40, 1'b0};
        vecs[4] = '{1'b1, 32'h102, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 32'h0,
                    1'b1, 1'b0, 5'd3, 32'h44, 1'b0, 32'h40, 1'b1};
        vecs[5] = '{1'b1, 32'h101, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 32'h0,
                    1'b1, 1'b0, 5'd9, 32'h44, 1'b0, 32'h40, 1'b1};
        vecs[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0,
                    1'b0, 1'b0, 5'd9, 32'h44, 1'b0, 32'h40, 1'b0};

        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        idle_ex();
        step();
        step();
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_redir", {31'd0, redirect_valid}, 32'd0);
        rst = 1'b0;

        // Back-to-back single-cycle ops from the table.
        for (int i = 0; i < 7; i++) begin
            set_ex(vecs[i].v, vecs[i].alu, 32'hCAFE, vecs[i].mr, vecs[i].mw, vecs[i].rw,
                   vecs[i].m2r, vecs[i].rd, vecs[i].tk, vecs[i].na);
            step();
            chk($sformatf("v%0d_wbv", i), {31'd0, wb_valid}, {31'd0, vecs[i].e_wbv});
            chk($sformatf("v%0d_wbrw", i), {31'd0, wb_reg_write}, {31'd0, vecs[i].e_rw});
            chk($sformatf("v%0d_wbrd", i), {27'd0, wb_rd}, {27'd0, vecs[i].e_rd});
            chk($sformatf("v%0d_wbdata", i), wb_data, vecs[i].e_data);
            chk($sformatf("v%0d_rv", i), {31'd0, redirect_valid}, {31'd0, vecs[i].e_rv});
            chk($sformatf("v%0d_ra", i), redirect_addr, vecs[i].e_ra);
            chk($sformatf("v%0d_mis", i), {31'd0, err_misalign}, {31'd0, vecs[i].e_mis});
            chk($sformatf("v%0d_stall", i), {31'd0, stall_o}, 32'd0);
            chk($sformatf("v%0d_req", i), {31'd0, dmem_req}, 32'd0);
        end

        // Load 0x100, ack in the third request cycle; ex inputs must be ignored while busy.
        set_ex(1'b1, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 32'h0);
        step();
        set_ex(1'b1, 32'h77, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b1, 32'h99);
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("ld_req_c%0d", c), {31'd0, dmem_req}, 32'd1);
            chk($sformatf("ld_stall_c%0d", c), {31'd0, stall_o}, 32'd1);
            chk($sformatf("ld_addr_c%0d", c), dmem_addr, 32'h100);
            chk($sformatf("ld_we_c%0d", c), {31'd0, dmem_we}, 32'd0);
            chk($sformatf("ld_wbv_c%0d", c), {31'd0, wb_valid}, 32'd0);
            if (c == 2) begin
                chk("ld_no_redir", {31'd0, redirect_valid}, 32'd0);
            end
            if (c == 3) begin
                idle_ex();
                dmem_ack = 1'b1;
                dmem_rdata = 32'hDEADBEEF;
            end
            step();
        end
        dmem_ack = 1'b0;
        chk("ld_done_req", {31'd0, dmem_req}, 32'd0);
        chk("ld_done_stall", {31'd0, stall_o}, 32'd0);
        chk("ld_done_wbv", {31'd0, wb_valid}, 32'd1);
        chk("ld_done_data", wb_data, 32'hDEADBEEF);
        chk("ld_done_rd", {27'd0, wb_rd}, 32'd6);
        chk("ld_done_rw", {31'd0, wb_reg_write}, 32'd1);

        // Store 0x104 with load bit also set: handled as a store, acked in its first cycle.
        set_ex(1'b1, 32'h104, 32'h55, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 1'b0, 32'h0);
        step();
        idle_ex();
        chk("st_req", {31'd0, dmem_req}, 32'd1);
        chk("st_we", {31'd0, dmem_we}, 32'd1);
        chk("st_wdata", dmem_wdata, 32'h55);
        chk("st_addr", dmem_addr, 32'h104);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("st_done_wbv", {31'd0, wb_valid}, 32'd1);
        chk("st_done_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("st_done_req", {31'd0, dmem_req}, 32'd0);

        // Load with no ack: aborted after four request cycles.
        set_ex(1'b1, 32'h200, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 32'h0);
        step();
        idle_ex();
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("to_req_c%0d", c), {31'd0, dmem_req}, 32'd1);
            chk($sformatf("to_err_c%0d", c), {31'd0, err_timeout}, 32'd0);
            step();
        end
        chk("to_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("to_err", {31'd0, err_timeout}, 32'd1);
        chk("to_wbv", {31'd0, wb_valid}, 32'd1);
        chk("to_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("to_stall", {31'd0, stall_o}, 32'd0);
        step();
        chk("to_err_pulse", {31'd0, err_timeout}, 32'd0);
        chk("to_wbv_pulse", {31'd0, wb_valid}, 32'd0);

        // Same load, ack arriving in the fourth cycle wins over the abort.
        set_ex(1'b1, 32'h200, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 32'h0);
        step();
        idle_ex();
        for (int c = 1; c <= 3; c++) begin
            step();
        end
        chk("al_req_c4", {31'd0, dmem_req}, 32'd1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1234;
        step();
        chk("al_err", {31'd0, err_timeout}, 32'd0);
        chk("al_wbv", {31'd0, wb_valid}, 32'd1);
        chk("al_data", wb_data, 32'h1234);
        chk("al_rw", {31'd0, wb_reg_write}, 32'd1);
        // Ack held high while idle must be ignored.
        step();
        chk("idle_ack_wbv", {31'd0, wb_valid}, 32'd0);
        chk("idle_ack_req", {31'd0, dmem_req}, 32'd0);
        dmem_ack = 1'b0;

        // Taken branch on a load, then reset with a pending ack during the access.
        set_ex(1'b1, 32'h300, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 1'b1, 32'h40);
        step();
        idle_ex();
        chk("br_rv", {31'd0, redirect_valid}, 32'd1);
        chk("br_ra", redirect_addr, 32'h40);
        chk("br_req", {31'd0, dmem_req}, 32'd1);
        step();
        chk("br_rv_pulse", {31'd0, redirect_valid}, 32'd0);
        rst = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hBAD0BAD0;
        step();
        rst = 1'b0;
        dmem_ack = 1'b0;
        chk("rs_req", {31'd0, dmem_req}, 32'd0);
        chk("rs_stall", {31'd0, stall_o}, 32'd0);
        chk("rs_wbv", {31'd0, wb_valid}, 32'd0);
        chk("rs_ra", redirect_addr, 32'd0);
        chk("rs_err", {31'd0, err_timeout}, 32'd0);
        step();
        chk("rs_wbv_after", {31'd0, wb_valid}, 32'd0);
        chk("rs_data_after", wb_data, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
